// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// A single full_adder is walked across the operands LSB first, one bit per
// clock, with a carry flop closing the loop between bits. A start/busy/done
// handshake accepts operands and returns a registered sum and final carry.
// The result registers change only when the last bit has been added (or on
// reset), so a consumer can read the previous result during a new operation.

// One-bit full adder shared by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ c_in;
    assign carry_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Bit counter is one bit wider than strictly needed so WIDTH itself fits.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           next_state_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] s_sh_r;
    logic [WIDTH-1:0] s_next_s;
    logic [WIDTH-1:0] sum_r;
    logic             c_r;
    logic             carry_out_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] cnt_r;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic             last_bit_s;
    logic             accept_s;
    logic             finish_s;

    // The only adder in the datapath: current LSBs plus the running carry.
    full_adder u_fa (
        .a         (a_sh_r[0]),
        .b         (b_sh_r[0]),
        .c_in      (c_r),
        .sum       (fa_sum_s),
        .carry_out (fa_carry_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;

    // Next-state logic; start is only honoured in IDLE, so it cannot disturb
    // an operation in flight.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        last_bit_s   = (cnt_r == CNT_LAST);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    next_state_s = ST_DONE;
                    finish_s     = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // New sum bit enters at the MSB end; after WIDTH shifts the word is aligned.
    // Written as shift-then-overwrite so that WIDTH=1 needs no special case.
    always_comb begin
        s_next_s            = s_sh_r >> 1'b1;
        s_next_s[WIDTH-1]   = fa_sum_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    // Serial datapath: operands are captured only on the accepting edge and
    // then consumed one bit per RUN edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            s_sh_r <= {WIDTH{1'b0}};
            c_r    <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else if (accept_s) begin
            a_sh_r <= a;
            b_sh_r <= b;
            c_r    <= c_in;
            cnt_r  <= CNT_ZERO;
        end else if (state_r == ST_RUN) begin
            a_sh_r <= a_sh_r >> 1'b1;
            b_sh_r <= b_sh_r >> 1'b1;
            s_sh_r <= s_next_s;
            c_r    <= fa_carry_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            a_sh_r <= a_sh_r;
            b_sh_r <= b_sh_r;
            s_sh_r <= s_sh_r;
            c_r    <= c_r;
            cnt_r  <= cnt_r;
        end
    end

    // Result registers: updated only when the final bit is added.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
        end else if (finish_s) begin
            sum_r       <= s_next_s;
            carry_out_r <= fa_carry_s;
        end else begin
            sum_r       <= sum_r;
            carry_out_r <= carry_out_r;
        end
    end

endmodule
